// File: rtl/ex_div_pkg.sv
// Shared CPU definitions used by ID/EX and the multi-cycle divider:
// divider state encodings, iteration count, start/stop levels and aluop codes.
package ex_div_pkg;

   localparam int DIV_W      = 32;
   localparam int DIV_CYCLES = 32;

   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

   // aluop codes decoded in ID and consumed by EX to launch the divider
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   // Two's complement negation when neg is set, pass-through otherwise.
   function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] x, input logic neg);
      return neg ? (~x + 1'b1) : x;
   endfunction

endpackage

// File: rtl/ex_div_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface ex_div_if;
   import ex_div_pkg::*;

   logic                 signed_div_i;
   logic [DIV_W-1:0]     opdata1_i;
   logic [DIV_W-1:0]     opdata2_i;
   logic                 start_i;
   logic                 annul_i;
   logic [2*DIV_W-1:0]   result_o;
   logic                 ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );

endinterface

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the EX stage: one load edge, 32 shift/subtract
// edges and one sign fix-up edge; result {remainder, quotient} is held until released.
module ex_div
   import ex_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic     clk,
   input  logic     rst,
   ex_div_if.slave  bus
);

   div_state_e           state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [2*WIDTH:0]     dividend, dividend_n;
   logic [WIDTH-1:0]     divisor, divisor_n;
   logic                 sdiv, sdiv_n;
   logic                 s1, s1_n;
   logic                 s2, s2_n;
   logic [2*WIDTH-1:0]   result, result_n;
   logic                 ready, ready_n;
   logic [WIDTH-1:0]     quot, rem;

   // One restoring step: trial-subtract the divisor from the partial remainder.
   function automatic logic [2*WIDTH:0] div_step(input logic [2*WIDTH:0] d,
                                                 input logic [WIDTH-1:0] v);
      logic [WIDTH:0] t;
      t = {1'b0, d[2*WIDTH-1:WIDTH]} - {1'b0, v};
      if (t[WIDTH])
         return {d[2*WIDTH-1:0], 1'b0};
      return {t[WIDTH-1:0], d[WIDTH-1:0], 1'b1};
   endfunction

   // Quotient sign follows s1^s2, remainder sign follows the dividend.
   assign quot = mag(dividend[WIDTH-1:0], sdiv & (s1 ^ s2));
   assign rem  = mag(dividend[2*WIDTH:WIDTH+1], sdiv & s1);

   assign bus.result_o = result;
   assign bus.ready_o  = ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DIV_FREE;
         cnt      <= '0;
         dividend <= '0;
         divisor  <= '0;
         sdiv     <= 1'b0;
         s1       <= 1'b0;
         s2       <= 1'b0;
         result   <= '0;
         ready    <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         dividend <= dividend_n;
         divisor  <= divisor_n;
         sdiv     <= sdiv_n;
         s1       <= s1_n;
         s2       <= s2_n;
         result   <= result_n;
         ready    <= ready_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      dividend_n = dividend;
      divisor_n  = divisor;
      sdiv_n     = sdiv;
      s1_n       = s1;
      s2_n       = s2;
      result_n   = result;
      ready_n    = ready;

      case (state)
         DIV_FREE: begin
            ready_n  = 1'b0;
            result_n = '0;
            if (bus.start_i == DIV_START && !bus.annul_i) begin
               // Operands and sign info are captured here; EX may change them afterwards.
               sdiv_n     = bus.signed_div_i;
               s1_n       = bus.opdata1_i[WIDTH-1];
               s2_n       = bus.opdata2_i[WIDTH-1];
               dividend_n = {{WIDTH{1'b0}},
                             mag(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[WIDTH-1]),
                             1'b0};
               cnt_n      = '0;
               if (bus.opdata2_i == '0) begin
                  state_n = DIV_BYZERO;
               end else begin
                  state_n   = DIV_ON;
                  divisor_n = mag(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[WIDTH-1]);
               end
            end
         end

         DIV_BYZERO: begin
            if (bus.annul_i) begin
               state_n  = DIV_FREE;
               ready_n  = 1'b0;
               result_n = '0;
            end else begin
               state_n  = DIV_END;
               ready_n  = 1'b1;
               result_n = '0;
            end
         end

         DIV_ON: begin
            if (bus.annul_i) begin
               state_n  = DIV_FREE;
               cnt_n    = '0;
               ready_n  = 1'b0;
               result_n = '0;
            end else if (cnt < CNT_W'(DIV_CYCLES)) begin
               dividend_n = div_step(dividend, divisor);
               cnt_n      = cnt + 1'b1;
            end else begin
               state_n  = DIV_END;
               cnt_n    = '0;
               ready_n  = 1'b1;
               result_n = {rem, quot};
            end
         end

         DIV_END: begin
            if (bus.annul_i || bus.start_i == DIV_STOP) begin
               state_n  = DIV_FREE;
               ready_n  = 1'b0;
               result_n = '0;
            end
         end

         default: state_n = DIV_FREE;
      endcase
   end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: a vector table of divides with expected results and
// latencies, plus hand-written annul / reset / ignored-request sequences.
module tb_ex_div;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_div_if bus ();

   ex_div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs [11];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
   endtask

   // Latency counts edges from the accepting edge inclusive.
   task automatic run_div(input vec_t v, input bit annul_release);
      int edges;
      bus.signed_div_i = v.sgn;
      bus.opdata1_i    = v.a;
      bus.opdata2_i    = v.b;
      bus.start_i      = 1'b1;
      bus.annul_i      = 1'b0;
      tick();
      edges = 1;
      bus.opdata1_i    = 32'hDEAD_BEEF;
      bus.opdata2_i    = 32'h0;
      bus.signed_div_i = ~v.sgn;
      while (!bus.ready_o && edges < 60) begin
         tick();
         edges++;
      end
      check({v.name, " latency"}, 64'(edges), 64'(v.lat));
      check({v.name, " result"}, bus.result_o, v.exp);
      tick();
      check({v.name, " hold ready"}, 64'(bus.ready_o), 64'd1);
      check({v.name, " hold result"}, bus.result_o, v.exp);
      if (annul_release) bus.annul_i = 1'b1;
      else               bus.start_i = 1'b0;
      tick();
      check({v.name, " release ready"}, 64'(bus.ready_o), 64'd0);
      check({v.name, " release result"}, bus.result_o, 64'd0);
      idle();
   endtask

   // Watches ready for n edges; reports the count of edges on which it was high.
   task automatic watch_quiet(input string name, input int n);
      int highs;
      highs = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.ready_o) highs++;
      end
      check(name, 64'(highs), 64'd0);
   endtask

   initial begin
      vecs[0]  = '{"u 100/7",      1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 34};
      vecs[1]  = '{"s -7/2",       1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 34};
      vecs[2]  = '{"s 7/-2",       1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 34};
      vecs[3]  = '{"u 5/0",        1'b0, 32'd5,         32'd0,         64'h0,                  2};
      vecs[4]  = '{"s min/-1",     1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 34};
      vecs[5]  = '{"u max/16",     1'b0, 32'hFFFFFFFF,  32'h00000010,  64'h0000000F_0FFFFFFF, 34};
      vecs[6]  = '{"s -100/-7",    1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 34};
      vecs[7]  = '{"u 2^31/max",   1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 34};
      vecs[8]  = '{"u max/1",      1'b0, 32'hFFFFFFFF,  32'h00000001,  64'h00000000_FFFFFFFF, 34};
      vecs[9]  = '{"s -7/0",       1'b1, 32'hFFFFFFF9,  32'h00000000,  64'h0,                  2};
      vecs[10] = '{"u 0xFFFFFFF9/2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 34};

      idle();
      rst = 1'b1;
      tick();
      tick();
      check("reset ready", 64'(bus.ready_o), 64'd0);
      check("reset result", bus.result_o, 64'd0);
      rst = 1'b0;
      tick();

      foreach (vecs[i]) run_div(vecs[i], (i == 5));

      // Annul 10 edges into the iteration phase; start drops with the annul.
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd1000;
      bus.opdata2_i    = 32'd3;
      bus.start_i      = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) tick();
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      tick();
      check("annul on result", bus.result_o, 64'd0);
      idle();
      watch_quiet("annul on quiet", 40);
      run_div('{"u 9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34}, 1'b0);

      // Annul while in the divide-by-zero state.
      bus.opdata1_i = 32'd5;
      bus.opdata2_i = 32'd0;
      bus.start_i   = 1'b1;
      tick();
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      tick();
      idle();
      watch_quiet("annul byzero quiet", 5);

      // start with annul in FREE must not launch a divide.
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      bus.start_i   = 1'b1;
      bus.annul_i   = 1'b1;
      tick();
      idle();
      watch_quiet("start+annul ignored", 40);

      // Synchronous reset at cnt=20 mid-divide.
      bus.opdata1_i = 32'd1000;
      bus.opdata2_i = 32'd3;
      bus.start_i   = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) tick();
      rst = 1'b1;
      tick();
      check("mid reset ready", 64'(bus.ready_o), 64'd0);
      check("mid reset result", bus.result_o, 64'd0);
      rst = 1'b0;
      bus.start_i   = 1'b0;
      bus.opdata1_i = 32'h1234_5678;
      bus.opdata2_i = 32'h0000_0000;
      watch_quiet("post reset quiet", 40);
      check("post reset result", bus.result_o, 64'd0);
      idle();
      run_div('{"u 1000/3 after reset", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 34}, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
